ifu_fetch: RTL and testbench

Instruction fetch unit for the 32-bit RISC-V core. It is the producer side of the `instruct` word that the instruction decoder consumes. It holds the PC and runs a request/response handshake with instruction memory. It presents each fetched word to decode/execute with a valid/ready handshake, then computes the next PC from the decoder's `jump_o`, `branch_o` and `mrs1andpc_ctr2` outputs and the execute-stage results.

---
 rtl/ifu_fetch_if.sv | 36 +++
 rtl/ifu_fetch.sv | 155 +++++++++++++++
 tb/tb_ifu_fetch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_if
// Instruction-memory bus between the fetch unit (master) and instruction
// memory (slave).
//
// Signals:
//   imem_req    master->slave  one-cycle fetch request
//   imem_addr   master->slave  fetch address, meaningful while imem_req=1
//   imem_rvalid slave->master  fetch data valid
//   imem_rdata  slave->master  fetched instruction word
//
// Handshake: imem_req is a one-cycle pulse with no ready/stall. Each request
// is answered by exactly one imem_rvalid pulse carrying imem_rdata, no
// earlier than the cycle after the request. The master accepts a response
// only while it is waiting for one; any other imem_rvalid is dropped.
// ---------------------------------------------------------------------------
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit for the 32-bit RISC-V core. Holds the PC, fetches
// one word at a time from instruction memory, presents it to decode/execute
// and computes the next PC from the decoder and execute-stage results.
//
// Ports:
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   imem               instruction-memory bus (master side)
//   instruct           registered instruction word to the decoder
//   instr_valid        instruct/pc_o valid
//   instr_ready        decode/execute retires the current instruction
//   pc_o               PC of instruct
//   jump_o             jal/jalr from the decoder
//   mrs1andpc_ctr2     1 = jalr (register target)
//   branch_o           00 none, 01 beq, 10 bne, 11 compare branch
//   imm                sign-extended immediate offset
//   jalr_target        rs1+imm from the ALU
//   alu_zero           ALU result is zero
//   cmp_true           ALU compare condition met
//   misalign_err       sticky: a computed target had bits[1:0] != 0
//   bus_err            sticky: fetch response timed out
//   instret            retired instruction count (wraps)
//   fsm_state          current FSM state (debug)
//
// Issue handshake: instruct/pc_o are held stable while instr_valid=1 and
// instr_ready=0; the instruction retires on the rising edge where both are 1.
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instruct,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc_o,
  input  logic               jump_o,
  input  logic               mrs1andpc_ctr2,
  input  logic [1:0]         branch_o,
  input  logic [31:0]        imm,
  input  logic [31:0]        jalr_target,
  input  logic               alu_zero,
  input  logic               cmp_true,
  output logic               misalign_err,
  output logic               bus_err,
  output logic [31:0]        instret,
  output logic [2:0]         fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]       state_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_inc;

  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic        branch_taken;

  // Next-PC selection; only consumed in the ISSUE cycle that retires.
  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    pc_plus_imm  = pc_q + imm;
    branch_taken = ((branch_o == 2'b01) &&  alu_zero) ||
                   ((branch_o == 2'b10) && !alu_zero) ||
                   ((branch_o == 2'b11) &&  cmp_true);
    if (jump_o && mrs1andpc_ctr2) begin
      // jalr clears only bit 0; a set bit 1 is left for the misalign check.
      next_pc = jalr_target & ~32'h1;
    end else if (jump_o || branch_taken) begin
      next_pc = pc_plus_imm;
    end else begin
      next_pc = pc_plus4;
    end
  end

  assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instruct     <= NOP;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      instret      <= 32'd0;
      wait_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            instruct    <= imem.imem_rdata;
            instr_valid <= 1'b1;
            wait_cnt_q  <= '0;
            state_q     <= S_ISSUE;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_cnt_inc == CNT_LAST) begin
              bus_err <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            pc_q        <= next_pc;
            instr_valid <= 1'b0;
            instret     <= instret + 32'd1;
            if (next_pc[1:0] != 2'b00) begin
              misalign_err <= 1'b1;
              state_q      <= S_ERR;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_ERR: begin
          // Terminal until reset.
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign pc_o           = pc_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rstn_w = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  ifu_fetch_if bus();
  logic [31:0] instruct, pc_o, imm, jalr_target, instret;
  logic        instr_valid, instr_ready, jump_o, mrs1andpc_ctr2;
  logic        alu_zero, cmp_true, misalign_err, bus_err;
  logic [1:0]  branch_o;
  logic [2:0]  fsm_state;

  ifu_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem           (bus.master),
    .instruct       (instruct),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_o           (pc_o),
    .jump_o         (jump_o),
    .mrs1andpc_ctr2 (mrs1andpc_ctr2),
    .branch_o       (branch_o),
    .imm            (imm),
    .jalr_target    (jalr_target),
    .alu_zero       (alu_zero),
    .cmp_true       (cmp_true),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err),
    .instret        (instret),
    .fsm_state      (fsm_state)
  );

  // ---------------- wrap-around DUT (RESET_PC at top of memory) ----------------
  ifu_fetch_if bus_w();
  logic [31:0] w_instruct, w_pc_o, w_instret;
  logic        w_valid, w_ready, w_mis, w_berr;
  logic [2:0]  w_state;
  logic        w_zero1 = 1'b0;
  logic [1:0]  w_zero2 = 2'b00;
  logic [31:0] w_zero32 = 32'd0;

  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TIMEOUT)) u_dut_wrap (
    .clk            (clk),
    .rstn           (rstn_w),
    .imem           (bus_w.master),
    .instruct       (w_instruct),
    .instr_valid    (w_valid),
    .instr_ready    (w_ready),
    .pc_o           (w_pc_o),
    .jump_o         (w_zero1),
    .mrs1andpc_ctr2 (w_zero1),
    .branch_o       (w_zero2),
    .imm            (w_zero32),
    .jalr_target    (w_zero32),
    .alu_zero       (w_zero1),
    .cmp_true       (w_zero1),
    .misalign_err   (w_mis),
    .bus_err        (w_berr),
    .instret        (w_instret),
    .fsm_state      (w_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  logic [31:0] last_word;
  logic        prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j, input logic jr,
                                             input logic [1:0] br, input logic z, input logic c,
                                             input logic [31:0] im, input logic [31:0] jt);
    logic take;
    take = (br == 2'b01 && z) || (br == 2'b10 && !z) || (br == 2'b11 && c);
    if (j && jr) return jt & 32'hFFFF_FFFE;
    if (j || take) return pc + im;
    return pc + 32'd4;
  endfunction

  // Every request must be expected, one cycle wide, at the expected address.
  always @(negedge clk) begin
    if (bus.imem_req) begin
      check("req_one_cycle", {31'd0, prev_req}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_req", {31'd0, bus.imem_req}, 32'd0);
      else check("fetch_addr", bus.imem_addr, exp_q.pop_front());
    end
    prev_req = bus.imem_req;
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_dec();
    jump_o = 1'b0; mrs1andpc_ctr2 = 1'($urandom_range(0, 1)); branch_o = 2'b00;
    imm = $urandom; jalr_target = $urandom;
    alu_zero = 1'($urandom_range(0, 1)); cmp_true = 1'($urandom_range(0, 1));
  endtask

  // Serves the pending request, holds ISSUE for 'hold' cycles, then retires
  // with the given decoder/execute inputs and checks the outcome.
  task automatic run_instr(input logic [31:0] word, input int lat, input int hold,
                           input logic j, input logic jr, input logic [1:0] br,
                           input logic z, input logic c, input logic [31:0] im,
                           input logic [31:0] jt, input logic [31:0] exp_next,
                           input logic exp_mis);
    int t;
    t = 0;
    while (!bus.imem_req && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.imem_req) begin
      check("req_seen", {31'd0, bus.imem_req}, 32'd1);
      return;
    end
    @(posedge clk); #1;
    repeat (lat) begin @(posedge clk); #1; end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = word;
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
    last_word = word;
    check("issue_valid", {31'd0, instr_valid}, 32'd1);
    check("issue_instr", instruct, word);
    check("issue_pc", pc_o, m_pc);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instruct, word);
      check("hold_pc", pc_o, m_pc);
      check("hold_instret", instret, m_instret);
    end
    jump_o = j; mrs1andpc_ctr2 = jr; branch_o = br; alu_zero = z; cmp_true = c;
    imm = im; jalr_target = jt; instr_ready = 1'b1;
    if (!exp_mis) exp_q.push_back(exp_next);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    randomize_dec();
    m_instret = m_instret + 32'd1;
    m_pc = exp_next;
    check("retire_instret", instret, m_instret);
    check("retire_pc", pc_o, exp_next);
    check("retire_valid", {31'd0, instr_valid}, 32'd0);
    check("misalign_flag", {31'd0, misalign_err}, {31'd0, exp_mis});
    check("next_state", {29'd0, fsm_state}, exp_mis ? {29'd0, S_ERR} : {29'd0, S_REQ});
  endtask

  task automatic release_reset();
    m_pc = 32'd0; m_instret = 32'd0;
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic nop_at(input logic [31:0] pc, input int lat, input int hold);
    run_instr(NOP, lat, hold, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40, 32'h0, pc + 32'd4, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic j, jr, z, c;
    logic [1:0] br;
    logic [31:0] im, jt, nx;

    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    bus_w.imem_rvalid = 1'b0; bus_w.imem_rdata = 32'd0;
    instr_ready = 1'b0; w_ready = 1'b0;
    randomize_dec();
    m_pc = 32'd0; m_instret = 32'd0; last_word = NOP;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_instr", instruct, NOP);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_state", {29'd0, fsm_state}, {29'd0, S_IDLE});

    release_reset();
    check("idle_no_req", {31'd0, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    check("first_req_edge1", {31'd0, bus.imem_req}, 32'd1);

    // Four sequential nops, zero-wait memory
    for (int i = 0; i < 4; i++) nop_at(32'(i * 4), 0, 0);
    check("instret_after_4", instret, 32'd4);

    // beq taken / not taken, bne, hold, jalr, jal, compare branch
    run_instr(32'h0000_0063, 0, 0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h08, 1'b0);
    nop_at(32'h08, 0, 0);
    nop_at(32'h0C, 0, 0);
    run_instr(32'h0000_0063, 0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h14, 1'b0);
    run_instr(32'h0000_1063, 1, 5, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h18, 1'b0);
    run_instr(32'h0000_1063, 0, 0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h20, 1'b0);
    run_instr(32'h0000_0067, 2, 0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 32'h0000_0040, 32'h101, 32'h100, 1'b0);
    run_instr(32'h0200_006F, 0, 1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0020, 32'h8, 32'h120, 1'b0);
    run_instr(32'h0000_4063, 0, 0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0, 32'h20, 1'b0);
    run_instr(32'h0000_4063, 3, 0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h24, 1'b0);

    // Random aligned control flow against the model
    for (int i = 0; i < 10; i++) begin
      j  = ($urandom_range(0, 3) == 0);
      jr = 1'($urandom_range(0, 1));
      br = 2'($urandom_range(0, 3));
      z  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      im = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFD;
      nx = model_next(m_pc, j, jr, br, z, c, im, jt);
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2), j, jr, br, z, c, im, jt, nx, 1'b0);
    end

    // Misaligned jalr target -> ERR, no further fetch
    run_instr(32'h0000_0067, 0, 0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h106, 32'h106, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      check("err_valid", {31'd0, instr_valid}, 32'd0);
      check("err_state", {29'd0, fsm_state}, {29'd0, S_ERR});
    end
    check("err_misalign_sticky", {31'd0, misalign_err}, 32'd1);

    // Asynchronous reset out of ERR
    #2 rstn = 1'b0;
    #1;
    check("arst_misalign", {31'd0, misalign_err}, 32'd0);
    check("arst_pc", pc_o, 32'd0);
    check("arst_state", {29'd0, fsm_state}, {29'd0, S_IDLE});
    check("arst_instret", instret, 32'd0);
    release_reset();
    nop_at(32'h0, 0, 0);

    // Fetch timeout at pc 0x4
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      @(posedge clk); #1;
      check("timeout_wait_state", {29'd0, fsm_state}, {29'd0, S_WAIT});
    end
    check("timeout_not_yet", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    check("timeout_bus_err", {31'd0, bus_err}, 32'd1);
    check("timeout_state", {29'd0, fsm_state}, {29'd0, S_ERR});
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hABCD_1234;
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0;
    check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rvalid_instr", instruct, last_word);
    repeat (3) @(posedge clk);
    #1;
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_bus_err", {31'd0, bus_err}, 32'd0);
    check("arst_addr", bus.imem_addr, 32'd0);
    release_reset();
    run_instr(32'h0000_0297, 0, 0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0);

    // Reset asserted mid-fetch (in WAIT at pc 0x4)
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midfetch_state", {29'd0, fsm_state}, {29'd0, S_WAIT});
    #2 rstn = 1'b0;
    #1;
    check("midfetch_rst_state", {29'd0, fsm_state}, {29'd0, S_IDLE});
    check("midfetch_rst_addr", bus.imem_addr, 32'd0);
    check("midfetch_rst_instr", instruct, NOP);
    check("midfetch_rst_instret", instret, 32'd0);

    // PC wrap with RESET_PC = 0xFFFF_FFFC
    check("wrap_rst_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rstn_w = 1'b1;
    @(posedge clk); #1;
    check("wrap_req", {31'd0, bus_w.imem_req}, 32'd1);
    check("wrap_req_addr", bus_w.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    bus_w.imem_rvalid = 1'b1; bus_w.imem_rdata = NOP;
    @(posedge clk); #1;
    bus_w.imem_rvalid = 1'b0;
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_pc", w_pc_o, 32'hFFFF_FFFC);
    w_ready = 1'b1;
    @(posedge clk); #1;
    w_ready = 1'b0;
    check("wrap_next_req", {31'd0, bus_w.imem_req}, 32'd1);
    check("wrap_next_addr", bus_w.imem_addr, 32'h0000_0000);
    check("wrap_instret", w_instret, 32'd1);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
